switch_control_rr: RTL and testbench

- Arbitration stage directly downstream of the per-node ant/routing agent.
- Consumes the N×M output-request matrix, including multicast requests such as 5'b10100 from ant packets, and issues one-hot grants per output port to the switch datapath.
- Issues a per-input "served" pulse so the input buffers can pop.
- Each output uses round-robin fairness. Multicast requests are served piecewise across cycles until every requested output has carried the flit.

---
 rtl/switch_control_rr_if.sv | 28 ++
 rtl/switch_control_rr.sv | 84 ++++++++
 tb/tb_switch_control_rr.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_control_rr_if.sv
// Request/grant bundle between the routing agent,
// the arbiter and the switch datapath.
interface switch_control_rr_if #(
  parameter int N = 5,
  parameter int M = 5
);
  logic [0:N-1][0:M-1] i_output_req;
  logic [0:M-1]        i_en;
  logic [0:M-1][0:N-1] o_output_grant;
  logic [0:N-1]        o_input_grant;
  logic [0:M-1]        o_busy;

  modport master (
    output i_output_req,
    output i_en,
    input  o_output_grant,
    input  o_input_grant,
    input  o_busy
  );

  modport slave (
    input  i_output_req,
    input  i_en,
    output o_output_grant,
    output o_input_grant,
    output o_busy
  );
endinterface

// File: rtl/switch_control_rr.sv
// Per-output round-robin switch arbiter with
// piecewise multicast service and served pulses.
module switch_control_rr #(
  parameter int N = 5,
  parameter int M = 5
) (
  input logic             clk,
  input logic             reset_n,
  switch_control_rr_if.slave bus
);

  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int PW1 = PW + 1;

  logic [M-1:0][PW-1:0] ptr;
  logic [M-1:0][PW-1:0] gsel;
  logic [0:M-1]         gv;
  logic [0:M-1][0:N-1]  gnt;
  logic [0:N-1][0:M-1]  served;
  logic [0:N-1][0:M-1]  eff;
  logic [0:N-1][0:M-1]  nserved;
  logic [0:N-1]         done;

  assign eff = bus.i_output_req & ~served;

  // Scan ptr, ptr+1, ... mod N; first eligible wins.
  always_comb begin
    logic [PW:0] sum;
    sum  = '0;
    gv   = '0;
    gsel = '0;
    gnt  = '0;
    for (int j = 0; j < M; j++) begin
      if (bus.i_en[j]) begin
        for (int k = 0; k < N; k++) begin
          sum = {1'b0, ptr[j]} + PW1'(k);
          if (sum >= PW1'(N))
            sum = sum - PW1'(N);
          if (!gv[j] && eff[sum[PW-1:0]][j]) begin
            gv[j]   = 1'b1;
            gsel[j] = sum[PW-1:0];
          end
        end
      end
      if (gv[j])
        gnt[j][gsel[j]] = 1'b1;
    end
  end

  // Served bits only survive for outputs still requested.
  always_comb begin
    nserved = '0;
    done    = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++)
        nserved[i][j] = bus.i_output_req[i][j]
                      & (served[i][j] | gnt[j][i]);
      done[i] = (|bus.i_output_req[i])
              && ((bus.i_output_req[i] & ~nserved[i]) == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.o_output_grant <= '0;
      bus.o_input_grant  <= '0;
      bus.o_busy         <= '0;
      served             <= '0;
      ptr                <= '0;
    end else begin
      bus.o_output_grant <= gnt;
      bus.o_input_grant  <= done;
      bus.o_busy         <= gv;
      for (int i = 0; i < N; i++)
        served[i] <= done[i] ? '0 : nserved[i];
      for (int j = 0; j < M; j++) begin
        if (gv[j])
          ptr[j] <= (gsel[j] == PW'(N - 1))
                  ? '0 : gsel[j] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_control_rr.sv
// Random and directed checks of switch_control_rr
// against a cycle-level reference model.
module tb_switch_control_rr;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  switch_control_rr_if #(.N(5), .M(5)) bus ();

  switch_control_rr #(.N(5), .M(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int              mptr [5];
  bit              msrv [5][5];
  logic [0:4][0:4] e_og;
  logic [0:4]      e_ig;
  logic [0:4]      e_busy;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%h exp=%h",
               tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 5; j++) begin
      mptr[j] = 0;
      for (int i = 0; i < 5; i++)
        msrv[i][j] = 1'b0;
    end
    e_og   = '0;
    e_ig   = '0;
    e_busy = '0;
  endtask

  // Expected registered outputs for the current inputs.
  task automatic model_step();
    logic [0:4][0:4] og;
    logic [0:4]      ig;
    logic [0:4]      by;
    og = '0;
    ig = '0;
    by = '0;
    for (int j = 0; j < 5; j++) begin
      int gi;
      gi = -1;
      if (bus.i_en[j]) begin
        for (int k = 0; k < 5; k++) begin
          int i;
          i = (mptr[j] + k) % 5;
          if (gi < 0 && bus.i_output_req[i][j]
              && !msrv[i][j])
            gi = i;
        end
      end
      if (gi >= 0) begin
        og[j][gi] = 1'b1;
        by[j]     = 1'b1;
        mptr[j]   = (gi + 1) % 5;
      end
    end
    for (int i = 0; i < 5; i++) begin
      bit any;
      bit left;
      any  = 1'b0;
      left = 1'b0;
      for (int j = 0; j < 5; j++) begin
        if (bus.i_output_req[i][j]) begin
          any = 1'b1;
          if (!msrv[i][j] && !og[j][i])
            left = 1'b1;
        end
      end
      if (any && !left)
        ig[i] = 1'b1;
      for (int j = 0; j < 5; j++) begin
        if (!any || !left)
          msrv[i][j] = 1'b0;
        else
          msrv[i][j] = bus.i_output_req[i][j]
                     && (msrv[i][j] || og[j][i]);
      end
    end
    e_og   = og;
    e_ig   = ig;
    e_busy = by;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("og", 32'(bus.o_output_grant), 32'(e_og));
    chk("ig", 32'(bus.o_input_grant), 32'(e_ig));
    chk("busy", 32'(bus.o_busy), 32'(e_busy));
  endtask

  task automatic clr_in();
    bus.i_output_req = '0;
    bus.i_en         = 5'b11111;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clr_in();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Upstream holds each request until its pulse.
  task automatic rand_cyc(int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (e_ig[i] || $urandom_range(0, 19) == 0) begin
          if ($urandom_range(0, 3) == 0)
            bus.i_output_req[i] = '0;
          else
            bus.i_output_req[i] =
              5'($urandom_range(1, 31));
        end
      end
      for (int j = 0; j < 5; j++)
        bus.i_en[j] = ($urandom_range(0, 3) != 0);
      cyc();
    end
  endtask

  logic [0:4] rr_exp [4];

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    clr_in();

    // reset mid-traffic, then ptr must be 0
    do_reset();
    rand_cyc(30);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_og", 32'(bus.o_output_grant), 32'd0);
    chk("rst_ig", 32'(bus.o_input_grant), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    model_reset();
    clr_in();
    @(negedge clk);
    reset_n = 1'b1;
    bus.i_output_req[1] = 5'b01000;
    bus.i_output_req[3] = 5'b01000;
    cyc();
    chk("rst_first", 32'(bus.o_output_grant[1]),
        32'(5'b01000));

    // single unicast
    do_reset();
    bus.i_output_req[2] = 5'b00100;
    cyc();
    chk("uc_og2", 32'(bus.o_output_grant[2]),
        32'(5'b00100));
    chk("uc_ig", 32'(bus.o_input_grant), 32'(5'b00100));
    bus.i_output_req = '0;
    cyc();
    chk("uc_idle", 32'(bus.o_output_grant), 32'd0);

    // round-robin contention on output 1
    do_reset();
    rr_exp[0] = 5'b10000;
    rr_exp[1] = 5'b01000;
    rr_exp[2] = 5'b00010;
    rr_exp[3] = 5'b10000;
    bus.i_output_req[0] = 5'b01000;
    bus.i_output_req[1] = 5'b01000;
    bus.i_output_req[3] = 5'b01000;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("rr_og1", 32'(bus.o_output_grant[1]),
          32'(rr_exp[c]));
      chk("rr_ig", 32'(bus.o_input_grant),
          32'(rr_exp[c]));
    end

    // multicast partial service, ptr[2] moved to 1
    do_reset();
    bus.i_output_req[0] = 5'b00100;
    cyc();
    bus.i_output_req[0] = '0;
    bus.i_output_req[4] = 5'b10100;
    bus.i_output_req[1] = 5'b00100;
    cyc();
    chk("mc_og0", 32'(bus.o_output_grant[0]),
        32'(5'b00001));
    chk("mc_og2", 32'(bus.o_output_grant[2]),
        32'(5'b01000));
    chk("mc_ig1", 32'(bus.o_input_grant),
        32'(5'b01000));
    bus.i_output_req[1] = '0;
    cyc();
    chk("mc_og2b", 32'(bus.o_output_grant[2]),
        32'(5'b00001));
    chk("mc_ig4", 32'(bus.o_input_grant),
        32'(5'b00001));

    // back-pressure on output 3
    do_reset();
    bus.i_output_req[0] = 5'b00010;
    bus.i_en = 5'b11101;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("bp_og", 32'(bus.o_output_grant), 32'd0);
      chk("bp_ig", 32'(bus.o_input_grant), 32'd0);
    end
    bus.i_en = 5'b11111;
    cyc();
    chk("bp_og3", 32'(bus.o_output_grant[3]),
        32'(5'b10000));
    chk("bp_ig0", 32'(bus.o_input_grant),
        32'(5'b10000));

    // request withdrawal mid-multicast
    do_reset();
    bus.i_output_req[2] = 5'b11000;
    bus.i_en = 5'b10111;
    cyc();
    chk("wd_og0", 32'(bus.o_output_grant[0]),
        32'(5'b00100));
    chk("wd_ig0", 32'(bus.o_input_grant), 32'd0);
    bus.i_output_req[2] = 5'b01000;
    bus.i_en = 5'b11111;
    cyc();
    chk("wd_og1", 32'(bus.o_output_grant[1]),
        32'(5'b00100));
    chk("wd_og0b", 32'(bus.o_output_grant[0]), 32'd0);
    chk("wd_ig", 32'(bus.o_input_grant),
        32'(5'b00100));

    // long random run
    do_reset();
    rand_cyc(400);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
